store_trace_buffer: RTL

- Sits directly downstream of the single-cycle processor's data-memory write port (memwrite, dataadr, writedata).
- Captures every store into a small FIFO, drains it to a checker or logger over a valid/ready interface, and tracks drops.
- Latches the first store to a configurable "done" address, so benches and FPGA tops get a sticky pass/stop flag instead of sampling memwrite on the falling clock edge.

---
 rtl/trace_pkg.sv | 15 +
 rtl/store_trace_buffer_if.sv | 26 ++
 rtl/store_trace_buffer_sync_fifo.sv | 62 ++++++
 rtl/store_trace_buffer.sv | 82 ++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// Shared defaults and the trace entry type for the store trace buffer.
package trace_pkg;

    localparam int          TRACE_AW        = 32;
    localparam int          TRACE_DW        = 32;
    localparam int          TRACE_DEPTH     = 8;
    localparam logic [31:0] TRACE_STOP_ADDR = 32'h0000_0008;

    // One captured store: byte address plus write data.
    typedef struct packed {
        logic [TRACE_AW-1:0] addr;
        logic [TRACE_DW-1:0] data;
    } trace_entry_t;

endpackage

// File: rtl/store_trace_buffer_if.sv
// Store input bus and trace output stream of the store trace buffer.
// slave is the buffer itself; master is the processor/consumer side.
interface store_trace_buffer_if #(
    parameter int AW = 32,
    parameter int DW = 32
);

    logic          memwrite;
    logic [AW-1:0] dataadr;
    logic [DW-1:0] writedata;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_addr;
    logic [DW-1:0] out_data;

    modport slave (
        input  memwrite, dataadr, writedata, out_ready,
        output out_valid, out_addr, out_data
    );

    modport master (
        output memwrite, dataadr, writedata, out_ready,
        input  out_valid, out_addr, out_data
    );

endinterface

// File: rtl/store_trace_buffer_sync_fifo.sv
// Synchronous FIFO: power-of-two depth, registered pointers, occupancy count.
// A push while full is only accepted when a pop frees the slot in the same cycle.
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           wdata,
    output logic [W-1:0]           rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          wr_en;
    logic          rd_en;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;

    // Head entry straight from storage; the read pointer is registered.
    assign rdata = mem[rd_ptr];

    // Storage, pointers and occupancy update.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            // NOTE: storage is cleared so the head outputs read 0 after reset, never X.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            if (wr_en) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/store_trace_buffer.sv
// Captures processor stores into a FIFO, streams them out over valid/ready,
// counts dropped stores and latches the first store to STOP_ADDR.
module store_trace_buffer
    import trace_pkg::*;
#(
    parameter int            DEPTH     = TRACE_DEPTH,
    parameter int            AW        = TRACE_AW,
    parameter int            DW        = TRACE_DW,
    parameter logic [AW-1:0] STOP_ADDR = AW'(TRACE_STOP_ADDR)
) (
    input  logic                   clk,
    input  logic                   reset,
    store_trace_buffer_if.slave    bus,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic [7:0]             drop_count,
    output logic                   stop_hit,
    output logic [DW-1:0]          stop_data
);

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } entry_t;

    entry_t wr_entry;
    entry_t head;
    logic   full;
    logic   empty;
    logic   pop;
    logic   drop;
    logic   stop_match;

    assign wr_entry   = '{addr: bus.dataadr, data: bus.writedata};
    assign pop        = bus.out_valid && bus.out_ready;
    assign drop       = bus.memwrite && full && !pop;
    assign stop_match = bus.memwrite && (bus.dataadr == STOP_ADDR) && !stop_hit;

    assign bus.out_valid = !empty;
    assign bus.out_addr  = head.addr;
    assign bus.out_data  = head.data;

    sync_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(entry_t))
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (bus.memwrite),
        .pop   (pop),
        .wdata (wr_entry),
        .rdata (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    // Drop accounting: sticky overflow flag and a saturating drop counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow   <= 1'b0;
            drop_count <= 8'd0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_count != 8'hFF) begin
                drop_count <= drop_count + 8'd1;
            end
        end
    end

    // Stop detection: first store to STOP_ADDR wins, whether or not it is buffered.
    always_ff @(posedge clk) begin
        if (reset) begin
            stop_hit  <= 1'b0;
            stop_data <= '0;
        end else if (stop_match) begin
            stop_hit  <= 1'b1;
            stop_data <= bus.writedata;
        end
    end

endmodule
